round_sequencer: RTL and testbench

Game-round controller for the light-chase bomb module. It sequences the chase datapath through idle, ready-blink, play, win and lose phases. It generates the per-level chase tick, advances the speed level on correct presses, counts strikes on wrong presses, and runs the countdown timer. The chase/LED datapath and the HEX display driver consume its outputs.

---
 rtl/round_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game-round controller for the light-chase bomb module
// Sequences idle/ready/play/win/lose and drives chase tick, level, strikes and countdown.
module round_sequencer #(
  parameter int CLK_HZ       = 50000000,
  parameter int READY_DIV    = 25000000,
  parameter int DIV_L1       = 50000000,
  parameter int DIV_L2       = 25000000,
  parameter int DIV_L3       = 12500000,
  parameter int READY_TICKS  = 8,
  parameter int MAX_STRIKES  = 3,
  parameter int TIME_LIMIT_S = 99
) (
  input  logic       MAX10_CLK1_50,
  input  logic       KEY0,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic       tick,
  output logic       clear,
  output logic [1:0] level,
  output logic       phase_ready,
  output logic       phase_play,
  output logic [1:0] strikes,
  output logic [6:0] time_left,
  output logic       game_win,
  output logic       game_lose
);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_PLAY, S_WIN, S_LOSE} state_t;

  localparam logic [31:0] READY_P  = 32'(READY_DIV);
  localparam logic [31:0] L1_P     = 32'(DIV_L1);
  localparam logic [31:0] L2_P     = 32'(DIV_L2);
  localparam logic [31:0] L3_P     = 32'(DIV_L3);
  localparam logic [31:0] SEC_LAST = 32'(CLK_HZ - 1);
  localparam logic [31:0] RDY_LAST = 32'(READY_TICKS - 1);
  localparam logic [1:0]  MAX_STR  = 2'(MAX_STRIKES);
  localparam logic [6:0]  TL_INIT  = 7'(TIME_LIMIT_S);

  state_t      state_q, state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] sec_cnt_q, sec_cnt_d;
  logic [31:0] rdy_cnt_q, rdy_cnt_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  strikes_q, strikes_d;
  logic [6:0]  time_left_q, time_left_d;
  logic        tick_q, tick_d;
  logic        clear_q, clear_d;
  logic        ready_q, ready_d;
  logic        play_q, play_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;

  logic [31:0] period;
  logic [1:0]  strikes_inc;
  logic        tick_hit, sec_hit, restart, active;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    rdy_cnt_d   = rdy_cnt_q;
    level_d     = level_q;
    strikes_d   = strikes_q;
    time_left_d = time_left_q;
    clear_d     = 1'b0;
    restart     = 1'b0;
    strikes_inc = strikes_q + 2'd1;
    active      = (state_q == S_READY) || (state_q == S_PLAY);

    period = READY_P;
    if (state_q == S_PLAY) begin
      case (level_q)
        2'd2:    period = L2_P;
        2'd3:    period = L3_P;
        default: period = L1_P;
      endcase
    end
    tick_hit = (tick_cnt_q == period - 32'd1);
    sec_hit  = (sec_cnt_q == SEC_LAST);

    if (!active) begin
      if (start) begin
        state_d     = S_READY;
        level_d     = 2'd1;
        strikes_d   = 2'd0;
        time_left_d = TL_INIT;
        sec_cnt_d   = 32'd0;
        clear_d     = 1'b1;
        restart     = 1'b1;
      end
    end else begin
      tick_cnt_d = tick_hit ? 32'd0 : tick_cnt_q + 32'd1;
      sec_cnt_d  = sec_hit ? 32'd0 : sec_cnt_q + 32'd1;
      if (sec_hit && time_left_q != 7'd0) begin
        time_left_d = time_left_q - 7'd1;
      end
      // Timeout outranks everything, then miss, then hit.
      if (sec_hit && time_left_q == 7'd1) begin
        state_d = S_LOSE;
        level_d = 2'd0;
      end else if (state_q == S_READY) begin
        if (tick_q) begin
          rdy_cnt_d = rdy_cnt_q + 32'd1;
          if (rdy_cnt_q == RDY_LAST) begin
            state_d = S_PLAY;
            restart = 1'b1;
          end
        end
      end else if (miss) begin
        strikes_d = strikes_inc;
        if (strikes_inc == MAX_STR) begin
          state_d = S_LOSE;
          level_d = 2'd0;
        end
      end else if (hit) begin
        if (level_q == 2'd3) begin
          state_d = S_WIN;
          level_d = 2'd0;
        end else begin
          state_d = S_READY;
          level_d = level_q + 2'd1;
          clear_d = 1'b1;
          restart = 1'b1;
        end
      end
    end

    if (restart) begin
      tick_cnt_d = 32'd0;
      rdy_cnt_d  = 32'd0;
    end

    // A step is only emitted while the phase continues; a restart or exit swallows it.
    tick_d  = active && tick_hit && !restart && (state_d == state_q);
    ready_d = (state_d == S_READY);
    play_d  = (state_d == S_PLAY);
    win_d   = (state_d == S_WIN);
    lose_d  = (state_d == S_LOSE);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= 32'd0;
      sec_cnt_q   <= 32'd0;
      rdy_cnt_q   <= 32'd0;
      level_q     <= 2'd0;
      strikes_q   <= 2'd0;
      time_left_q <= 7'd0;
      tick_q      <= 1'b0;
      clear_q     <= 1'b0;
      ready_q     <= 1'b0;
      play_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      rdy_cnt_q   <= rdy_cnt_d;
      level_q     <= level_d;
      strikes_q   <= strikes_d;
      time_left_q <= time_left_d;
      tick_q      <= tick_d;
      clear_q     <= clear_d;
      ready_q     <= ready_d;
      play_q      <= play_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign tick        = tick_q;
  assign clear       = clear_q;
  assign level       = level_q;
  assign phase_ready = ready_q;
  assign phase_play  = play_q;
  assign strikes     = strikes_q;
  assign time_left   = time_left_q;
  assign game_win    = win_q;
  assign game_lose   = lose_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer
// Per-game stimulus tables feed a cycle-stamped scoreboard; tick timing is logged separately.
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       KEY0 = 1'b0;
  logic       start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic       tick, clear, phase_ready, phase_play, game_win, game_lose;
  logic [1:0] level, strikes;
  logic [6:0] time_left;

  round_sequencer #(
    .CLK_HZ(20), .READY_DIV(4), .DIV_L1(8), .DIV_L2(6), .DIV_L3(4),
    .READY_TICKS(4), .MAX_STRIKES(3), .TIME_LIMIT_S(5)
  ) dut (
    .MAX10_CLK1_50(clk), .KEY0(KEY0), .start(start), .hit(hit), .miss(miss),
    .tick(tick), .clear(clear), .level(level), .phase_ready(phase_ready),
    .phase_play(phase_play), .strikes(strikes), .time_left(time_left),
    .game_win(game_win), .game_lose(game_lose)
  );

  always #5 clk = ~clk;

  // {tick, clear, level, ready, play, strikes, time_left, win, lose}
  logic [16:0] dut_vec;
  assign dut_vec = {tick, clear, level, phase_ready, phase_play, strikes, time_left,
                    game_win, game_lose};

  typedef struct {
    int          at;
    logic        s;
    logic        h;
    logic        m;
    logic [16:0] exp;
  } rec_t;

  typedef struct {
    int          cyc;
    int          at;
    logic [16:0] exp;
  } sb_t;

  rec_t  tbl[$];
  sb_t   sb[$];
  int    tick_seen[$];
  int    tick_exp[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    tick_origin = 0;
  string test_name = "reset";

  function automatic logic [16:0] mk(logic tk, logic cl, logic [1:0] lv, logic rd, logic pl,
                                     logic [1:0] st, logic [6:0] tl, logic w, logic l);
    return {tk, cl, lv, rd, pl, st, tl, w, l};
  endfunction

  function automatic void add(int at, logic s, logic h, logic m, logic [16:0] e);
    rec_t r;
    r.at = at; r.s = s; r.h = h; r.m = m; r.exp = e;
    tbl.push_back(r);
  endfunction

  task automatic check_vec(input string name, input logic [16:0] exp);
    n_cmp++;
    if (dut_vec !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got=%05h exp=%05h", test_name, name, dut_vec, exp);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic m);
    start = s; hit = h; miss = m;
    @(posedge clk);
    #1;
    start = 1'b0; hit = 1'b0; miss = 1'b0;
    @(negedge clk);
    cyc++;
    if (tick === 1'b1) tick_seen.push_back(cyc - tick_origin);
  endtask

  task automatic do_reset();
    KEY0 = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset_state", 17'd0);
    KEY0 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_vec("idle_after_reset", 17'd0);
  endtask

  // Cycle 0 is the first cycle after the edge that samples the table's start entry.
  task automatic run_table(input int last);
    int   idx, origin;
    logic s, h, m;
    sb_t  e;
    idx = 0;
    origin = cyc + 1;
    tick_origin = origin;
    tick_seen.delete();
    for (int c = 0; c <= last; c++) begin
      s = 1'b0; h = 1'b0; m = 1'b0;
      while (idx < tbl.size() && tbl[idx].at == c) begin
        s = tbl[idx].s; h = tbl[idx].h; m = tbl[idx].m;
        e.cyc = origin + c; e.at = c; e.exp = tbl[idx].exp;
        sb.push_back(e);
        idx++;
      end
      step(s, h, m);
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check_vec($sformatf("C%0d", e.at), e.exp);
      end
    end
    n_cmp++;
    if (sb.size() != 0 || idx != tbl.size()) begin
      n_fail++;
      $display("FAIL %s/scoreboard_drain left=%0d unused=%0d exp=0", test_name,
               sb.size(), tbl.size() - idx);
    end
    sb.delete();
    tbl.delete();
  endtask

  task automatic check_ticks();
    n_cmp++;
    if (tick_seen.size() != tick_exp.size()) begin
      n_fail++;
      $display("FAIL %s/tick_count got=%0d exp=%0d", test_name, tick_seen.size(), tick_exp.size());
    end
    for (int i = 0; i < tick_exp.size() && i < tick_seen.size(); i++) begin
      n_cmp++;
      if (tick_seen[i] != tick_exp[i]) begin
        n_fail++;
        $display("FAIL %s/tick%0d got=C%0d exp=C%0d", test_name, i, tick_seen[i], tick_exp[i]);
      end
    end
    tick_exp.delete();
  endtask

  task automatic exp_ready_ticks(input int entry);
    for (int k = 1; k <= 4; k++) tick_exp.push_back(entry + 4 * k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic READY blink then level-1 PLAY pacing and first second step.
    test_name = "t1_start";
    do_reset();
    add(0,  1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(1,  0, 0, 0, mk(0, 0, 1, 1, 0, 0, 5, 0, 0));
    add(4,  0, 0, 0, mk(1, 0, 1, 1, 0, 0, 5, 0, 0));
    add(16, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 5, 0, 0));
    add(17, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 5, 0, 0));
    add(19, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 5, 0, 0));
    add(20, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 4, 0, 0));
    add(25, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, 4, 0, 0));
    add(33, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, 4, 0, 0));
    run_table(34);
    exp_ready_ticks(0);
    tick_exp.push_back(25); tick_exp.push_back(33);
    check_ticks();

    // Climb all three levels and win.
    test_name = "t2_win";
    do_reset();
    add(0,  1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(17, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 5, 0, 0));
    add(18, 0, 1, 0, mk(0, 1, 2, 1, 0, 0, 5, 0, 0));
    add(19, 0, 0, 0, mk(0, 0, 2, 1, 0, 0, 5, 0, 0));
    add(35, 0, 0, 0, mk(0, 0, 2, 0, 1, 0, 4, 0, 0));
    add(41, 0, 0, 0, mk(1, 0, 2, 0, 1, 0, 3, 0, 0));
    add(42, 0, 1, 0, mk(0, 1, 3, 1, 0, 0, 3, 0, 0));
    add(59, 0, 0, 0, mk(0, 0, 3, 0, 1, 0, 3, 0, 0));
    add(63, 0, 0, 0, mk(1, 0, 3, 0, 1, 0, 2, 0, 0));
    add(67, 0, 0, 0, mk(1, 0, 3, 0, 1, 0, 2, 0, 0));
    add(68, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0));
    add(90, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0));
    run_table(90);
    exp_ready_ticks(0); exp_ready_ticks(18); tick_exp.push_back(41);
    exp_ready_ticks(42); tick_exp.push_back(63); tick_exp.push_back(67);
    check_ticks();

    // Three misses lose; the tick phase survives the misses.
    test_name = "t3_strikes";
    do_reset();
    add(0,  1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(17, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 5, 0, 0));
    add(18, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 5, 0, 0));
    add(21, 0, 0, 1, mk(0, 0, 1, 0, 1, 2, 4, 0, 0));
    add(25, 0, 0, 0, mk(1, 0, 1, 0, 1, 2, 4, 0, 0));
    add(27, 0, 0, 1, mk(0, 0, 0, 0, 0, 3, 4, 0, 1));
    add(40, 0, 0, 0, mk(0, 0, 0, 0, 0, 3, 4, 0, 1));
    run_table(45);
    exp_ready_ticks(0); tick_exp.push_back(25);
    check_ticks();

    // Simultaneous hit and miss at level 2 counts as a miss only.
    test_name = "t4_hit_and_miss";
    do_reset();
    add(0,  1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(18, 0, 1, 0, mk(0, 1, 2, 1, 0, 0, 5, 0, 0));
    add(35, 0, 0, 0, mk(0, 0, 2, 0, 1, 0, 4, 0, 0));
    add(36, 0, 1, 1, mk(0, 0, 2, 0, 1, 1, 4, 0, 0));
    add(41, 0, 0, 0, mk(1, 0, 2, 0, 1, 1, 3, 0, 0));
    add(47, 0, 0, 0, mk(1, 0, 2, 0, 1, 1, 3, 0, 0));
    run_table(47);
    exp_ready_ticks(0); exp_ready_ticks(18);
    tick_exp.push_back(41); tick_exp.push_back(47);
    check_ticks();

    // Countdown to zero with no presses.
    test_name = "t5_timeout";
    do_reset();
    add(0,   1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(19,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 5, 0, 0));
    add(20,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 4, 0, 0));
    add(40,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 3, 0, 0));
    add(60,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 2, 0, 0));
    add(80,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 1, 0, 0));
    add(99,  0, 0, 0, mk(0, 0, 1, 0, 1, 0, 1, 0, 0));
    add(100, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(120, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_table(120);
    exp_ready_ticks(0);
    for (int t = 25; t < 100; t += 8) tick_exp.push_back(t);
    check_ticks();

    // Final-level hit on the expiry edge still loses.
    test_name = "t5_timeout_vs_hit";
    do_reset();
    add(0,   1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(18,  0, 1, 0, mk(0, 1, 2, 1, 0, 0, 5, 0, 0));
    add(36,  0, 1, 0, mk(0, 1, 3, 1, 0, 0, 4, 0, 0));
    add(53,  0, 0, 0, mk(0, 0, 3, 0, 1, 0, 3, 0, 0));
    add(99,  0, 0, 0, mk(0, 0, 3, 0, 1, 0, 1, 0, 0));
    add(100, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(110, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_table(110);
    exp_ready_ticks(0); exp_ready_ticks(18); exp_ready_ticks(36);
    for (int t = 57; t < 100; t += 4) tick_exp.push_back(t);
    check_ticks();

    // Asynchronous reset between edges mid-PLAY, then a fresh game.
    test_name = "t6_async_reset";
    do_reset();
    add(0,  1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(18, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 5, 0, 0));
    run_table(20);
    #2;
    KEY0 = 1'b0;
    #1;
    check_vec("reset_between_edges", 17'd0);
    @(negedge clk);
    check_vec("reset_held", 17'd0);
    KEY0 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_vec("no_clear_after_release", 17'd0);
    add(0, 1, 0, 0, mk(0, 1, 1, 1, 0, 0, 5, 0, 0));
    add(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0, 5, 0, 0));
    add(4, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 5, 0, 0));
    run_table(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
